// File: rtl/bcrypt_pkg.sv
// Shared types, address map constants and word-select helpers for the
// bcrypt ExpandKey/ExpandState sequencer.
package bcrypt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KX_RD,
        ST_KX_WR,
        ST_ENC_START,
        ST_ENC_WAIT,
        ST_WR_HI,
        ST_WR_LO,
        ST_DONE
    } state_t;

    // SRAM word address of P[0] and of S[0][0]; the 1024 S words are contiguous.
    localparam logic [11:0] P_ARRAY_OFFSET = 12'd4000;
    localparam logic [11:0] S_BOX_OFFSET   = 12'd0;

    // 18 P words, i.e. 9 P pairs, followed by 512 S pairs.
    localparam int NUM_P_WORDS = 18;
    localparam int NUM_P_PAIRS = NUM_P_WORDS / 2;
    localparam int NUM_PAIRS   = 521;

    // Key word idx, with word 0 in the most significant 32 bits.
    function automatic logic [31:0] key_word(input logic [575:0] key, input logic [4:0] idx);
        logic [575:0] shifted;
        shifted = key << {idx, 5'd0};
        return shifted[575:544];
    endfunction

    // Salt word idx, with word 0 in the most significant 32 bits.
    function automatic logic [31:0] salt_word(input logic [127:0] salt, input logic [1:0] idx);
        logic [127:0] shifted;
        shifted = salt << {idx, 5'd0};
        return shifted[127:96];
    endfunction

endpackage

// File: rtl/expand_key_ctrl.sv
// Sequencer for one bcrypt ExpandKey/ExpandState pass: XORs the key into the
// P-array in SRAM, then chains 521 Blowfish encryptions through the external
// feistel stage and writes each 64-bit result back over P and then S.
module expand_key_ctrl
    import bcrypt_pkg::*;
(
    input  logic         clk,
    input  logic         reset_l,
    input  logic         start,
    input  logic         salt_en,
    input  logic [575:0] key,
    input  logic [127:0] salt,
    output logic         busy,
    output logic         done,
    output logic         f_start,
    output logic [31:0]  f_L,
    output logic [31:0]  f_R,
    input  logic [63:0]  f_result,
    input  logic         f_done,
    output logic         mem_own,
    output logic         mem_cs_l,
    output logic         mem_we_l,
    output logic [11:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata
);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  word_idx;
    logic [9:0]  pair_idx;
    logic [31:0] L_r;
    logic [31:0] R_r;
    logic        salt_en_r;

    logic [31:0] white_l;
    logic [31:0] white_r;
    logic [9:0]  s_pair;
    logic [11:0] kx_addr;
    logic [11:0] pair_base;
    logic        last_word;
    logic        last_pair;

    // Address generation, salt whitening and end-of-loop detection for the current indices.
    always_comb begin
        white_l   = L_r ^ (salt_en_r ? salt_word(salt, {pair_idx[0], 1'b0}) : 32'd0);
        white_r   = R_r ^ (salt_en_r ? salt_word(salt, {pair_idx[0], 1'b1}) : 32'd0);
        s_pair    = pair_idx - 10'(NUM_P_PAIRS);
        kx_addr   = P_ARRAY_OFFSET + {7'd0, word_idx};
        last_word = (word_idx == 5'(NUM_P_WORDS - 1));
        last_pair = (pair_idx == 10'(NUM_PAIRS - 1));
        if (pair_idx < 10'(NUM_P_PAIRS)) begin
            pair_base = P_ARRAY_OFFSET + {1'b0, pair_idx, 1'b0};
        end else begin
            pair_base = S_BOX_OFFSET + {1'b0, s_pair, 1'b0};
        end
    end

    // State register; reset aborts a pass immediately with no rollback of SRAM.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and all outputs, decoded from the current state and registers.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        f_start   = 1'b0;
        f_L       = L_r;
        f_R       = R_r;
        mem_own   = 1'b0;
        mem_cs_l  = 1'b1;
        mem_we_l  = 1'b1;
        mem_addr  = 12'd0;
        mem_wdata = 32'd0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_KX_RD;
                end
            end
            ST_KX_RD: begin
                mem_own   = 1'b1;
                mem_cs_l  = 1'b0;
                mem_addr  = kx_addr;
                state_nxt = ST_KX_WR;
            end
            ST_KX_WR: begin
                mem_own   = 1'b1;
                mem_cs_l  = 1'b0;
                mem_we_l  = 1'b0;
                mem_addr  = kx_addr;
                mem_wdata = mem_rdata ^ key_word(key, word_idx);
                state_nxt = last_word ? ST_ENC_START : ST_KX_RD;
            end
            ST_ENC_START: begin
                f_start   = 1'b1;
                f_L       = white_l;
                f_R       = white_r;
                state_nxt = ST_ENC_WAIT;
            end
            ST_ENC_WAIT: begin
                if (f_done) begin
                    state_nxt = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                mem_own   = 1'b1;
                mem_cs_l  = 1'b0;
                mem_we_l  = 1'b0;
                mem_addr  = pair_base;
                mem_wdata = L_r;
                state_nxt = ST_WR_LO;
            end
            ST_WR_LO: begin
                mem_own   = 1'b1;
                mem_cs_l  = 1'b0;
                mem_we_l  = 1'b0;
                mem_addr  = pair_base + 12'd1;
                mem_wdata = R_r;
                state_nxt = last_pair ? ST_DONE : ST_ENC_START;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: indices, the chained L/R block and the salt enable captured at start.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            word_idx  <= 5'd0;
            pair_idx  <= 10'd0;
            L_r       <= 32'd0;
            R_r       <= 32'd0;
            salt_en_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        salt_en_r <= salt_en;
                        L_r       <= 32'd0;
                        R_r       <= 32'd0;
                        word_idx  <= 5'd0;
                        pair_idx  <= 10'd0;
                    end
                end
                ST_KX_WR: begin
                    word_idx <= last_word ? 5'd0 : word_idx + 5'd1;
                end
                ST_ENC_START: begin
                    L_r <= white_l;
                    R_r <= white_r;
                end
                ST_ENC_WAIT: begin
                    if (f_done) begin
                        L_r <= f_result[63:32];
                        R_r <= f_result[31:0];
                    end
                end
                ST_WR_LO: begin
                    if (!last_pair) begin
                        pair_idx <= pair_idx + 10'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expand_key_ctrl.sv
// Scoreboard bench for expand_key_ctrl: a pass-level reference model queues the
// expected SRAM writes and feistel inputs, and a monitor pops and compares them
// as the DUT produces them.
module tb_expand_key_ctrl;

    logic         clk = 1'b0;
    logic         reset_l;
    logic         start;
    logic         salt_en;
    logic [575:0] key;
    logic [127:0] salt;
    logic         busy;
    logic         done;
    logic         f_start;
    logic [31:0]  f_L;
    logic [31:0]  f_R;
    logic [63:0]  f_result;
    logic         f_done;
    logic         mem_own;
    logic         mem_cs_l;
    logic         mem_we_l;
    logic [11:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    expand_key_ctrl dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .start     (start),
        .salt_en   (salt_en),
        .key       (key),
        .salt      (salt),
        .busy      (busy),
        .done      (done),
        .f_start   (f_start),
        .f_L       (f_L),
        .f_R       (f_R),
        .f_result  (f_result),
        .f_done    (f_done),
        .mem_own   (mem_own),
        .mem_cs_l  (mem_cs_l),
        .mem_we_l  (mem_we_l),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] kw [18];
    logic [31:0] sw [4];
    logic [43:0] exp_wr[$];
    logic [63:0] exp_fs[$];

    // Free-running cycle count used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // SRAM copy A: registered read, optional clearing of the P region for directed tests.
    logic [31:0] sram [4096];
    bit clear_p = 1'b0;
    always @(posedge clk) begin
        if (clear_p) begin
            for (int i = 0; i < 18; i++) sram[4000 + i] <= 32'd0;
        end else if (!mem_cs_l) begin
            if (!mem_we_l) sram[mem_addr] <= mem_wdata;
            mem_rdata <= sram[mem_addr];
        end
    end

    // Behavioural feistel: identity or a fixed scrambling function.
    bit ident = 1'b1;
    bit rand_lat = 1'b0;
    bit stub_never = 1'b0;
    function automatic logic [63:0] feistel_fn(input logic [63:0] x, input bit id);
        if (id) return x;
        return {x[31:0] ^ 32'h9E3779B9, x[63:32] + x[31:0]};
    endfunction

    // Feistel stub: fixed 1-cycle or random 3..20 cycle latency, accumulating total wait cycles.
    int pend = 0;
    logic [63:0] cap;
    longint wait_sum = 0;
    always @(posedge clk or negedge reset_l) begin
        int l;
        if (!reset_l) begin
            pend     <= 0;
            f_done   <= 1'b0;
            f_result <= 64'd0;
        end else begin
            f_done <= 1'b0;
            if (f_start && !stub_never) begin
                l = rand_lat ? int'($urandom_range(3, 20)) : 1;
                pend     <= l;
                cap      <= {f_L, f_R};
                wait_sum <= wait_sum + longint'(l) + 1;
            end else if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) begin
                    f_done   <= 1'b1;
                    f_result <= feistel_fn(cap, ident);
                end
            end
        end
    end

    // Monitor: pops expectations on each write and f_start, checks hold stability during waits.
    int fs_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [11:0] last_wr_addr = 12'd0;
    bit waiting = 1'b0;
    bit hold_bad = 1'b0;
    logic [63:0] held;
    always @(negedge clk) begin
        if (!reset_l) begin
            waiting  = 1'b0;
            hold_bad = 1'b0;
        end else begin
            if (waiting) begin
                if ({f_L, f_R} !== held || mem_own !== 1'b0) hold_bad = 1'b1;
                if (f_done) begin
                    check_output("wait_hold", {127'd0, hold_bad}, 128'd0);
                    waiting  = 1'b0;
                    hold_bad = 1'b0;
                end
            end
            if (f_start) begin
                fs_cnt++;
                if (exp_fs.size() == 0) check_output("unexpected_f_start", {64'd0, f_L, f_R}, 128'd0);
                else check_output("f_LR", {64'd0, f_L, f_R}, {64'd0, exp_fs.pop_front()});
                held     = {f_L, f_R};
                waiting  = 1'b1;
                hold_bad = 1'b0;
            end
            if (!mem_cs_l && !mem_we_l) begin
                last_wr_addr = mem_addr;
                if (exp_wr.size() == 0) check_output("unexpected_write", {83'd0, mem_own, mem_addr, mem_wdata}, 128'd0);
                else check_output("write", {83'd0, mem_own, mem_addr, mem_wdata}, {83'd0, 1'b1, exp_wr.pop_front()});
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Pass-level reference: key XOR into P, then 521 chained (whitened) encryptions.
    task automatic build_model(input bit se);
        logic [31:0] l, r, a;
        logic [63:0] blk;
        for (int i = 0; i < 18; i++) exp_wr.push_back({12'(4000 + i), sram[4000 + i] ^ kw[i]});
        l = 32'd0;
        r = 32'd0;
        for (int k = 0; k < 521; k++) begin
            if (se) begin
                l = l ^ sw[(2 * k) % 4];
                r = r ^ sw[(2 * k + 1) % 4];
            end
            exp_fs.push_back({l, r});
            blk = feistel_fn({l, r}, ident);
            l = blk[63:32];
            r = blk[31:0];
            a = (k < 9) ? 32'(4000 + 2 * k) : 32'(2 * (k - 9));
            exp_wr.push_back({a[11:0], l});
            exp_wr.push_back({a[11:0] + 12'd1, r});
        end
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < 18; i++) key[575 - 32 * i -: 32] = kw[i];
        for (int i = 0; i < 4; i++) salt[127 - 32 * i -: 32] = sw[i];
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 18; i++) kw[i] = $urandom;
        for (int i = 0; i < 4; i++) sw[i] = $urandom;
        pack_inputs();
    endtask

    int start_cyc = 0;
    task automatic apply_stimulus(input bit record);
        @(posedge clk);
        #1 start = 1'b1;
        if (record) start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check_output(name,
            {14'd0, busy, done, f_start, mem_own, mem_cs_l, mem_we_l, mem_addr, mem_wdata, f_L, f_R},
            {14'd0, 4'b0000, 2'b11, 12'd0, 32'd0, 64'd0});
    endtask

    task automatic abort_with_reset();
        @(posedge clk);
        #3 reset_l = 1'b0;
        #1 check_reset_outputs("async_reset_outputs");
        exp_wr.delete();
        exp_fs.delete();
        @(negedge clk);
        reset_l = 1'b1;
    endtask

    // Runs one full pass and checks completion, drained scoreboard and latency.
    task automatic run_pass(input bit se, input bit mid_start);
        int d0;
        longint w0;
        build_model(se);
        salt_en = se;
        d0 = done_cnt;
        w0 = wait_sum;
        apply_stimulus(1'b1);
        if (mid_start) begin
            repeat (300 + $urandom_range(0, 200)) @(posedge clk);
            apply_stimulus(1'b0);
        end
        for (int i = 0; i < 20000 && done_cnt == d0; i++) @(posedge clk);
        repeat (12) @(posedge clk);
        #1;
        check_output("done_count", 128'(done_cnt - d0), 128'd1);
        check_output("writes_drained", 128'(exp_wr.size()), 128'd0);
        check_output("starts_drained", 128'(exp_fs.size()), 128'd0);
        check_output("latency", 128'(done_cyc - start_cyc), 128'(longint'(1 + 36 + 3 * 521) + (wait_sum - w0)));
        check_output("idle_after_done", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        int f0;
        reset_l = 1'b0;
        start   = 1'b0;
        salt_en = 1'b0;
        key     = '0;
        salt    = '0;
        #1 check_reset_outputs("reset_outputs");
        clear_p = 1'b1;
        @(posedge clk);
        #1 clear_p = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;

        // Key XOR phase only: feistel never answers, P starts at zero, key word i = i.
        for (int i = 0; i < 18; i++) kw[i] = 32'(i);
        for (int i = 0; i < 4; i++) sw[i] = 32'd0;
        pack_inputs();
        ident = 1'b1;
        stub_never = 1'b1;
        build_model(1'b0);
        salt_en = 1'b0;
        apply_stimulus(1'b1);
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) check_output($sformatf("kx_P%0d", i), {96'd0, sram[4000 + i]}, 128'(i));
        check_output("kx_only_p_writes", 128'(exp_wr.size()), 128'(2 * 521));
        check_output("busy_in_wait", {127'd0, busy}, 128'd1);
        abort_with_reset();
        stub_never = 1'b0;

        // Identity feistel, no salt: every chained block stays zero, ends at S word 1023.
        randomize_inputs();
        run_pass(1'b0, 1'b0);
        check_output("last_write_addr", {116'd0, last_wr_addr}, 128'd1023);

        // Identity feistel with salt {1,2,3,4}.
        randomize_inputs();
        sw[0] = 32'd1; sw[1] = 32'd2; sw[2] = 32'd3; sw[3] = 32'd4;
        pack_inputs();
        run_pass(1'b1, 1'b0);
        check_output("salt_P0", {96'd0, sram[4000]}, 128'd1);
        check_output("salt_P1", {96'd0, sram[4001]}, 128'd2);
        check_output("salt_P2", {96'd0, sram[4002]}, 128'd2);
        check_output("salt_P3", {96'd0, sram[4003]}, 128'd6);

        // Random latency, scrambling feistel, random salt, with a start pulse mid-pass.
        ident = 1'b0;
        rand_lat = 1'b1;
        randomize_inputs();
        run_pass(1'($urandom_range(0, 1)), 1'b1);

        // Reset during pair 100, then a full pass from whatever P now holds.
        randomize_inputs();
        build_model(1'b1);
        salt_en = 1'b1;
        f0 = fs_cnt;
        apply_stimulus(1'b1);
        for (int i = 0; i < 20000 && fs_cnt < f0 + 101; i++) @(posedge clk);
        check_output("reached_pair_100", 128'(fs_cnt - f0 >= 101), 128'd1);
        repeat ($urandom_range(0, 6)) @(posedge clk);
        abort_with_reset();
        randomize_inputs();
        run_pass(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
